// File: rtl/decoder_pkg.sv
// Shared constants and decode helpers for the scanning one-hot decoder.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  // Helpers work at a fixed maximum width; callers widen the index and
  // keep the low 2^N bits of the result.
  localparam int MAX_N = 10;
  localparam int MAX_W = 1 << MAX_N;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] i);
    logic [MAX_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] apply_pol(input logic [MAX_W-1:0] v,
                                                 input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control and result bundle of the scanning decoder.
interface decoder_scan_if #(parameter int N = 2);
  logic               en;
  logic               mode;
  logic               dir;
  logic               load;
  logic [N-1:0]       S;
  logic [(1<<N)-1:0]  D;
  logic [N-1:0]       idx;
  logic               valid;
  logic               wrap;

  modport master (output en, mode, dir, load, S, input D, idx, valid, wrap);
  modport slave  (input en, mode, dir, load, S, output D, idx, valid, wrap);
endinterface

// File: rtl/decoder_scan_dwell.sv
// Dwell counter: counts 0..DWELL-1 while inc is high; tick marks the last count.
module dwell_counter #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tick
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = inc && (r_cnt == CW'(DWELL - 1));

  // clear wins over increment; the count rolls to 0 on the tick
  always_ff @(posedge clk) begin
    if (!rst_n)   r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc) r_cnt <= tick ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N decoder with enable, output polarity and auto-scan.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int DWELL      = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);
  localparam int W = 1 << N;

  logic [N-1:0]     r_idx;
  logic [W-1:0]     r_d;
  logic             r_valid;
  logic             r_wrap;

  logic             w_clr;
  logic             w_inc;
  logic             w_tick;
  logic [N-1:0]     w_idx_nxt;
  logic             w_wrap_nxt;
  logic [MAX_W-1:0] w_dec_full;
  logic [W-1:0]     w_d_nxt;
  logic             w_unused_hi;

  // direct mode and load restart the dwell; scan without load advances it
  assign w_clr = bus.en && (bus.mode == MODE_DIRECT || bus.load);
  assign w_inc = bus.en && (bus.mode == MODE_SCAN) && !bus.load;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_inc),
    .tick  (w_tick)
  );

  // next index: take S in direct/load, else step on tick with wrap detect
  always_comb begin
    w_idx_nxt  = r_idx;
    w_wrap_nxt = 1'b0;
    if (bus.mode == MODE_DIRECT || bus.load) begin
      w_idx_nxt = bus.S;
    end else if (w_tick) begin
      if (bus.dir == DIR_DOWN) begin
        w_idx_nxt  = r_idx - N'(1);
        w_wrap_nxt = (r_idx == '0);
      end else begin
        w_idx_nxt  = r_idx + N'(1);
        w_wrap_nxt = (r_idx == '1);
      end
    end
  end

  assign w_dec_full  = apply_pol(onehot(MAX_N'(w_idx_nxt)), ACTIVE_LOW);
  assign w_d_nxt     = w_dec_full[W-1:0];
  // bits above 2^N are always inactive and intentionally dropped
  assign w_unused_hi = ^w_dec_full;

  // state update; disabled cycles blank D but keep the index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_d     <= {W{ACTIVE_LOW}};
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (!bus.en) begin
      r_d     <= {W{ACTIVE_LOW}};
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_d     <= w_d_nxt;
      r_valid <= 1'b1;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.D     = r_d;
  assign bus.idx   = r_idx;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;
endmodule
